// File: rtl/lzc_norm_pipe.sv
// rtl/lzc_norm_pipe.sv - two-stage elastic leading-zero counter with optional normalising left shift
// Define LZC_NORM_EN to build the stage-2 barrel shifter; otherwise out_norm is held at 0.
module lzc_norm_pipe #(
    parameter  int WIDTH = 16,
    parameter  int TAG_W = 8,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NIB = WIDTH / 4;

    generate
        if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("lzc_norm_pipe: WIDTH must be a power of two between 4 and 64");
        end
    endgenerate

    logic                  s1_valid;
    logic [NIB-1:0][1:0]   s1_nib_cnt;
    logic [NIB-1:0]        s1_nib_zero;
    logic [TAG_W-1:0]      s1_tag;
`ifdef LZC_NORM_EN
    logic [WIDTH-1:0]      s1_data;
`endif
    logic                  s2_valid;

    logic                  s1_load;
    logic                  s2_load;
    logic [NIB-1:0][1:0]   nib_cnt;
    logic [NIB-1:0]        nib_zero;
    logic [3:0]            nib;
    logic [CW-1:0]         cnt_c;
    logic                  zero_c;
    logic [WIDTH-1:0]      norm_c;

    // Stage 2 drains when empty or accepted; stage 1 moves whenever stage 2 does.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    always_comb begin
        nib_cnt  = '0;
        nib_zero = '0;
        nib      = '0;
        for (int j = 0; j < NIB; j++) begin
            nib         = in_data[4*j +: 4];
            nib_zero[j] = (nib == 4'd0);
            nib_cnt[j]  = {~nib[3] & ~nib[2], ~nib[3] & (nib[2] | ~nib[1])};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_nib_cnt  <= '0;
            s1_nib_zero <= '0;
            s1_tag      <= '0;
`ifdef LZC_NORM_EN
            s1_data     <= '0;
`endif
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_nib_cnt  <= nib_cnt;
                s1_nib_zero <= nib_zero;
                s1_tag      <= in_tag;
`ifdef LZC_NORM_EN
                s1_data     <= in_data;
`endif
            end
        end
    end

    // Ascending scan: the last non-zero nibble seen is the most significant one.
    always_comb begin
        cnt_c  = CW'(WIDTH);
        zero_c = 1'b1;
        for (int j = 0; j < NIB; j++) begin
            if (!s1_nib_zero[j]) begin
                cnt_c  = CW'((NIB - 1 - j) * 4) + CW'(s1_nib_cnt[j]);
                zero_c = 1'b0;
            end
        end
`ifdef LZC_NORM_EN
        norm_c = s1_data << cnt_c;
`else
        norm_c = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_count <= '0;
            out_zero  <= 1'b0;
            out_norm  <= '0;
            out_tag   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_count <= cnt_c;
                out_zero  <= zero_c;
                out_norm  <= norm_c;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb/tb_lzc_norm_pipe.sv - self-checking bench for lzc_norm_pipe (table vectors plus scoreboard)
module tb_lzc_norm_pipe;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  tag;
        logic [4:0]  cnt;
        logic        zero;
        logic [15:0] norm;
    } vec_t;

    typedef struct {
        vec_t v;
        int   cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [15:0] in_data, out_norm;
    logic [7:0]  in_tag, out_tag;
    logic [4:0]  out_count;

    logic        v32, r32, ov32, or32, oz32;
    logic [31:0] d32, on32;
    logic [3:0]  t32, ot32;
    logic [5:0]  oc32;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_push   = 0;
    int   n_pop    = 0;
    int   cyc      = 0;
    bit   lat_mode = 1'b0;
    bit   rand_done = 1'b0;
    vec_t exp_cur;
    vec_t tbl[10];
    sb_t  sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lzc_norm_pipe #(.WIDTH(16), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_zero(out_zero), .out_norm(out_norm), .out_tag(out_tag)
    );

    lzc_norm_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v32), .in_ready(r32), .in_data(d32), .in_tag(t32),
        .out_valid(ov32), .out_ready(or32), .out_count(oc32),
        .out_zero(oz32), .out_norm(on32), .out_tag(ot32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] nexp(input logic [15:0] n);
`ifdef LZC_NORM_EN
        return n;
`else
        return 16'h0 & n;
`endif
    endfunction

    function automatic vec_t ref_vec(input logic [15:0] d, input logic [7:0] t);
        vec_t r;
        bit   found = 1'b0;
        r.data = d;
        r.tag  = t;
        r.cnt  = 5'd16;
        for (int i = 15; i >= 0; i--) begin
            if (!found && d[i]) begin
                r.cnt = 5'(15 - i);
                found = 1'b1;
            end
        end
        r.zero = (d == 16'h0);
        r.norm = d << r.cnt;
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] d, input logic [7:0] t, input logic [4:0] c,
                                input logic z, input logic [15:0] n);
        vec_t r;
        r.data = d; r.tag = t; r.cnt = c; r.zero = z; r.norm = n;
        return r;
    endfunction

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got count %0d with empty scoreboard", out_count);
            end else begin
                e = sb.pop_front();
                n_pop++;
                chk("count", 64'(out_count), 64'(e.v.cnt));
                chk("zero", 64'(out_zero), 64'(e.v.zero));
                chk("norm", 64'(out_norm), 64'(nexp(e.v.norm)));
                chk("tag", 64'(out_tag), 64'(e.v.tag));
                if (lat_mode) chk("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
        if (rst_n && in_valid && in_ready) begin
            e.v   = exp_cur;
            e.cyc = cyc;
            sb.push_back(e);
            n_push++;
        end
    end

    task automatic send(input vec_t v);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = v.data;
        in_tag   = v.tag;
        exp_cur  = v;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        v32 = 1'b0; d32 = '0; t32 = '0; or32 = 1'b1;
        exp_cur = mk(16'h0, 8'h0, 5'd16, 1'b1, 16'h0);

        tbl[0] = mk(16'h8000, 8'h01, 5'd0,  1'b0, 16'h8000);
        tbl[1] = mk(16'h0001, 8'h02, 5'd15, 1'b0, 16'h8000);
        tbl[2] = mk(16'h00F0, 8'h03, 5'd8,  1'b0, 16'hF000);
        tbl[3] = mk(16'h0000, 8'h5A, 5'd16, 1'b1, 16'h0000);
        tbl[4] = mk(16'h0400, 8'h04, 5'd5,  1'b0, 16'h8000);
        tbl[5] = mk(16'h1234, 8'h05, 5'd3,  1'b0, 16'h91A0);
        tbl[6] = mk(16'h0F00, 8'h06, 5'd4,  1'b0, 16'hF000);
        tbl[7] = mk(16'h0008, 8'h07, 5'd12, 1'b0, 16'h8000);
        tbl[8] = mk(16'h7FFF, 8'h08, 5'd1,  1'b0, 16'hFFFE);
        tbl[9] = mk(16'h0030, 8'h09, 5'd10, 1'b0, 16'hC000);

        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_norm", 64'(out_norm), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 32-bit instance: one beat, latency 2, count 15
        v32 = 1'b1; d32 = 32'h0001_0000; t32 = 4'hC;
        @(posedge clk);
        #1 v32 = 1'b0;
        @(negedge clk);
        chk("w32_valid_early", 64'(ov32), 64'd0);
        @(negedge clk);
        chk("w32_valid", 64'(ov32), 64'd1);
        chk("w32_count", 64'(oc32), 64'd15);
        chk("w32_zero", 64'(oz32), 64'd0);
        chk("w32_tag", 64'(ot32), 64'hC);
`ifdef LZC_NORM_EN
        chk("w32_norm", 64'(on32), 64'h8000_0000);
`else
        chk("w32_norm", 64'(on32), 64'h0);
`endif
        chk("w32_in_ready", 64'(r32), 64'd1);
        @(posedge clk);
        #1;

        // table vectors back-to-back: results on consecutive cycles, latency 2
        lat_mode = 1'b1;
        for (int i = 0; i < 10; i++) send(tbl[i]);
        drain();

        // stall mid-stream: both stages fill, outputs hold, nothing lost
        lat_mode = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) send(ref_vec(16'h0001 << k, 8'h10 + 8'(k)));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_count", 64'(out_count), 64'd14);
                    chk("stall_tag", 64'(out_tag), 64'h11);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // asynchronous reset with two beats in flight
        send(ref_vec(16'h00FF, 8'hA1));
        send(ref_vec(16'h0F0F, 8'hA2));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_count", 64'(out_count), 64'd0);
        chk("arst_out_zero", 64'(out_zero), 64'd0);
        chk("arst_out_norm", 64'(out_norm), 64'd0);
        chk("arst_out_tag", 64'(out_tag), 64'd0);
        sb.delete();
        n_push = n_pop;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_mode = 1'b1;
        send(tbl[4]);
        drain();

        // randomised traffic with random valid gaps and backpressure
        lat_mode = 1'b0;
        fork
            begin
                for (int b = 0; b < 1000; b++) begin
                    logic [15:0] d;
                    d = 16'($urandom) >> $urandom_range(0, 16);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(ref_vec(d, 8'($urandom)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("push_pop_balance", 64'(n_pop), 64'(n_push));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
